// File: rtl/f33m_mult_batch_if.sv
// Start/done handshake plus operand and result buses for the batched GF(3^3M) multiplier.
// Each bus carries NCH channels of {e2,e1,e0}, EW = 2M bits per GF(3^M) element.
interface f33m_mult_batch_if #(
  parameter int M   = 97,
  parameter int NCH = 3
);
  localparam int EW = 2 * M;
  localparam int NB = NCH * 3 * EW;

  logic           start;
  logic           sq;
  logic [NCH-1:0] en;
  logic [NB-1:0]  a;
  logic [NB-1:0]  b;
  logic [NB-1:0]  c;
  logic           busy;
  logic           done;

  modport master (output start, sq, en, a, b, input c, busy, done);
  modport slave  (input start, sq, en, a, b, output c, busy, done);
endinterface

// File: rtl/f33m_mult_batch.sv
// Batched GF(3^3M) multiplier: enabled channels run in turn through one digit-serial GF(3^M) core (six Karatsuba products each).
// Latency 2 + popcount(en)*(6*(M+1)+14) cycles from start to done; no backpressure, start is ignored while busy.
module f33m_mult_batch #(
  parameter int M   = 97,
  parameter int NCH = 3,
  parameter int K   = 12   // GF(3^M) modulus is x^M + x^K + 2
) (
  input  logic             clk,
  input  logic             reset,
  f33m_mult_batch_if.slave bus
);
  localparam int EW  = 2 * M;
  localparam int W3  = 3 * EW;
  localparam int NB  = NCH * W3;
  localparam int CW  = $clog2(NCH + 1);
  localparam int SCW = $clog2(M);

  // Digit encoding 0=00, 1=01, 2=10 is the plain binary value, so a digit add is a mod-3 add.
  function automatic logic [1:0] f3_add(input logic [1:0] p, input logic [1:0] q);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, q};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] f3_neg(input logic [1:0] p);
    return {p[0], p[1]};
  endfunction

  function automatic logic [EW-1:0] f3m_add(input logic [EW-1:0] p, input logic [EW-1:0] q);
    logic [EW-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = f3_add(p[2*i +: 2], q[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [EW-1:0] f3m_neg(input logic [EW-1:0] p);
    logic [EW-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = f3_neg(p[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [EW-1:0] f3m_add3(input logic [EW-1:0] p, input logic [EW-1:0] q,
                                             input logic [EW-1:0] r);
    return f3m_add(f3m_add(p, q), r);
  endfunction

  function automatic logic [EW-1:0] f3m_add4(input logic [EW-1:0] p, input logic [EW-1:0] q,
                                             input logic [EW-1:0] r, input logic [EW-1:0] s);
    return f3m_add(f3m_add(p, q), f3m_add(r, s));
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_CAPT, S_COMB, S_FIN
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  ch, ch_nxt;
  logic [2:0]     k, k_nxt;
  int             ch_sel;
  logic           scan_found;
  logic [CW-1:0]  scan_idx;

  logic [NCH-1:0] en_cap;
  logic [NB-1:0]  a_cap, b_cap, c_q;
  logic [EW-1:0]  x [6];

  logic [W3-1:0]  a_ch, b_ch;
  logic [EW-1:0]  op_a, op_b;

  logic           sub_rst, sub_done;
  logic [SCW-1:0] sub_cnt;
  logic [EW-1:0]  sub_acc, sub_nxt, sub_red, sub_pp;
  logic [1:0]     sub_top, sub_dig;

  logic [EW-1:0]  d1, d2, d3, r0, r1, r2;

  // Square mode is folded in here so the datapath never looks at sq again.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.start) begin
      a_cap  <= bus.a;
      b_cap  <= bus.sq ? bus.a : bus.b;
      en_cap <= bus.en;
    end
  end

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en_cap[i] && i >= int'(ch)) begin
        scan_found = 1'b1;
        scan_idx   = CW'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    k_nxt     = k;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_SCAN;
          ch_nxt    = '0;
        end
      end
      S_SCAN: begin
        if (scan_found) begin
          ch_nxt    = scan_idx;
          k_nxt     = 3'd0;
          state_nxt = S_ISSUE;
        end else begin
          state_nxt = S_FIN;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (sub_done) state_nxt = S_CAPT;
      S_CAPT: begin
        if (k == 3'd5) begin
          state_nxt = S_COMB;
        end else begin
          k_nxt     = k + 3'd1;
          state_nxt = S_ISSUE;
        end
      end
      S_COMB: begin
        ch_nxt    = ch + CW'(1);
        state_nxt = S_SCAN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ch    <= '0;
      k     <= 3'd0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      k     <= k_nxt;
    end
  end

  // ch reaches NCH after the last channel; park the mux on channel 0 then.
  always_comb begin
    ch_sel = (int'(ch) < NCH) ? int'(ch) : 0;
    a_ch   = a_cap[ch_sel*W3 +: W3];
    b_ch   = b_cap[ch_sel*W3 +: W3];
    case (k)
      3'd0: begin
        op_a = a_ch[2*EW +: EW];
        op_b = b_ch[2*EW +: EW];
      end
      3'd1: begin
        op_a = f3m_add(a_ch[2*EW +: EW], a_ch[EW +: EW]);
        op_b = f3m_add(b_ch[2*EW +: EW], b_ch[EW +: EW]);
      end
      3'd2: begin
        op_a = a_ch[EW +: EW];
        op_b = b_ch[EW +: EW];
      end
      3'd3: begin
        op_a = f3m_add(a_ch[2*EW +: EW], a_ch[0 +: EW]);
        op_b = f3m_add(b_ch[2*EW +: EW], b_ch[0 +: EW]);
      end
      3'd4: begin
        op_a = f3m_add(a_ch[EW +: EW], a_ch[0 +: EW]);
        op_b = f3m_add(b_ch[EW +: EW], b_ch[0 +: EW]);
      end
      default: begin
        op_a = a_ch[0 +: EW];
        op_b = b_ch[0 +: EW];
      end
    endcase
  end

  // GF(3^M) core: Horner over b digits MSB first, one digit per cycle; done rises M cycles after
  // release and holds, so the product is still valid in CAPT before ISSUE resets the core again.
  assign sub_rst = reset || !(state == S_WAIT || state == S_CAPT);

  always_comb begin
    sub_top                = sub_acc[EW-1 -: 2];
    sub_red                = '0;
    sub_red[1:0]           = sub_top;
    sub_red[2*K +: 2]      = f3_neg(sub_top);
    sub_dig                = op_b[2*int'(sub_cnt) +: 2];
    case (sub_dig)
      2'b01:   sub_pp = op_a;
      2'b10:   sub_pp = f3m_neg(op_a);
      default: sub_pp = '0;
    endcase
    sub_nxt = f3m_add3({sub_acc[EW-3:0], 2'b00}, sub_red, sub_pp);
  end

  always_ff @(posedge clk) begin
    if (sub_rst) begin
      sub_acc  <= '0;
      sub_cnt  <= SCW'(M - 1);
      sub_done <= 1'b0;
    end else if (!sub_done) begin
      sub_acc <= sub_nxt;
      if (sub_cnt == '0) sub_done <= 1'b1;
      else               sub_cnt  <= sub_cnt - SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CAPT) x[k] <= sub_acc;
  end

  // Karatsuba recombination with y^3 = y + 1 folded in.
  always_comb begin
    d3 = f3m_add3(x[1], f3m_neg(x[0]), f3m_neg(x[2]));
    d1 = f3m_add3(x[4], f3m_neg(x[2]), f3m_neg(x[5]));
    d2 = f3m_add4(x[3], x[2], f3m_neg(x[0]), f3m_neg(x[5]));
    r0 = f3m_add(x[5], d3);
    r1 = f3m_add3(d1, d3, x[0]);
    r2 = f3m_add(d2, x[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= '0;
    end else if (state == S_COMB) begin
      c_q[ch_sel*W3 +: W3] <= {r2, r1, r0};
    end
  end

  assign bus.c    = c_q;
  assign bus.busy = (state != S_IDLE) && (state != S_FIN);
  assign bus.done = (state == S_FIN);

endmodule

// File: tb/tb_f33m_mult_batch.sv
// Bench for f33m_mult_batch at a small field size: hand-derived vector table, golden-model scoreboard,
// and sequences for mask, empty batch, stray start, mid-batch reset and back-to-back starts.
module tb_f33m_mult_batch;
  localparam int M      = 7;
  localparam int K      = 2;
  localparam int NCH    = 3;
  localparam int EW     = 2 * M;
  localparam int W3     = 3 * EW;
  localparam int NB     = NCH * W3;
  localparam int T_SUB  = M + 1;
  localparam int CH_CYC = 6 * T_SUB + 14;
  localparam int MAXW   = 2 + NCH * CH_CYC + 10;

  typedef logic [EW-1:0] el_t;
  typedef logic [W3-1:0] el3_t;
  typedef logic [NB-1:0] bus_t;

  typedef struct {
    logic           sq;
    logic [NCH-1:0] en;
    bus_t           a;
    bus_t           b;
    bus_t           c;
  } vec_t;

  typedef struct {
    bus_t c;
    int   lat;
    int   t0;
    int   tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   tag_n = 0;
  exp_t exp_q[$];
  bus_t c_model;
  vec_t tbl[5];

  f33m_mult_batch_if #(.M(M), .NCH(NCH)) bus ();
  f33m_mult_batch #(.M(M), .NCH(NCH), .K(K)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Golden model: schoolbook products, x^M = 2x^K + 1 in GF(3^M), y^3 = y + 1 in the extension.
  function automatic int dg(input el_t e, input int i);
    return int'(e[2*i +: 2]);
  endfunction

  function automatic el_t gm_add(input el_t p, input el_t q);
    el_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((dg(p, i) + dg(q, i)) % 3);
    return r;
  endfunction

  function automatic el_t gm_mul(input el_t p, input el_t q);
    int  t;
    int  pr[2*M-1];
    el_t r;
    for (int i = 0; i < 2*M-1; i++) pr[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) pr[i+j] += dg(p, i) * dg(q, j);
    for (int d = 2*M-2; d >= M; d--) begin
      t = pr[d] % 3;
      pr[d] = 0;
      pr[d-M]   += t;
      pr[d-M+K] += 2 * t;
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(pr[i] % 3);
    return r;
  endfunction

  function automatic el3_t gm33(input el3_t p, input el3_t q);
    el_t a0, a1, a2, b0, b1, b2, p0, p1, p2, p3, p4;
    a0 = p[0 +: EW]; a1 = p[EW +: EW]; a2 = p[2*EW +: EW];
    b0 = q[0 +: EW]; b1 = q[EW +: EW]; b2 = q[2*EW +: EW];
    p0 = gm_mul(a0, b0);
    p1 = gm_add(gm_mul(a0, b1), gm_mul(a1, b0));
    p2 = gm_add(gm_add(gm_mul(a0, b2), gm_mul(a1, b1)), gm_mul(a2, b0));
    p3 = gm_add(gm_mul(a1, b2), gm_mul(a2, b1));
    p4 = gm_mul(a2, b2);
    return {gm_add(p2, p4), gm_add(gm_add(p1, p3), p4), gm_add(p0, p3)};
  endfunction

  function automatic bus_t model(input logic s, input logic [NCH-1:0] e, input bus_t av,
                                 input bus_t bv, input bus_t cprev);
    bus_t r;
    el3_t ai;
    r = cprev;
    for (int i = 0; i < NCH; i++) begin
      ai = av[i*W3 +: W3];
      if (e[i]) r[i*W3 +: W3] = gm33(ai, s ? ai : el3_t'(bv[i*W3 +: W3]));
    end
    return r;
  endfunction

  function automatic el_t rand_el();
    el_t r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic bus_t rand_bus();
    bus_t r;
    for (int i = 0; i < 3*NCH; i++) r[i*EW +: EW] = rand_el();
    return r;
  endfunction

  function automatic el3_t el3(input el_t e2, input el_t e1, input el_t e0);
    return {e2, e1, e0};
  endfunction

  task automatic chk_bus(input string nm, input bus_t got, input bus_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Called at a negedge; raises start for one cycle, then scrambles the inputs.
  task automatic launch(input logic s, input logic [NCH-1:0] e, input bus_t av, input bus_t bv,
                        input bus_t expc);
    exp_t x;
    x.c   = expc;
    x.lat = 2 + $countones(e) * CH_CYC;
    x.t0  = cyc;
    x.tag = tag_n++;
    exp_q.push_back(x);
    bus.start = 1'b1;
    bus.sq    = s;
    bus.en    = e;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sq    = 1'($urandom_range(0, 1));
    bus.en    = NCH'($urandom);
    bus.a     = rand_bus();
    bus.b     = rand_bus();
  endtask

  // Returns at the negedge of the cycle after done, where a back-to-back start can be driven.
  task automatic wait_done();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: done seen with no batch outstanding");
      return;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL batch%0d done: not seen within %0d cycles, expected after %0d", e.tag, MAXW, e.lat);
      return;
    end
    chk_int($sformatf("batch%0d latency", e.tag), cyc - e.t0, e.lat);
    chk_bus($sformatf("batch%0d c", e.tag), bus.c, e.c);
    chk_bit($sformatf("batch%0d busy in done cycle", e.tag), bus.busy, 1'b0);
    @(negedge clk);
    chk_bit($sformatf("batch%0d done pulse width", e.tag), bus.done, 1'b0);
  endtask

  initial begin
    el_t  one, two, z, xm1, x1, red;
    bus_t av, bv, ec;
    logic s;
    logic [NCH-1:0] e;

    one = el_t'(1);
    two = el_t'(2);
    z   = '0;
    xm1 = el_t'(1) << (2 * (M - 1));
    x1  = el_t'(1) << 2;
    red = el_t'(1) | (el_t'(2) << (2 * K));

    tbl[0] = '{1'b0, 3'b111,
               {el3(two, z, z), el3(one, z, z), el3(z, one, z)},
               {el3(z, one, z), el3(one, z, z), el3(one, z, z)},
               {el3(z, two, two), el3(one, one, z), el3(z, one, one)}};
    tbl[1] = '{1'b0, 3'b010,
               {el3(z, z, z), el3(z, one, z), el3(z, z, z)},
               {el3(z, z, z), el3(z, one, z), el3(z, z, z)},
               {el3(z, two, two), el3(one, z, z), el3(z, one, one)}};
    tbl[2] = '{1'b1, 3'b100,
               {el3(one, one, one), el3(z, z, z), el3(z, z, z)},
               {NB{1'b1}},
               {el3(one, two, z), el3(one, z, z), el3(z, one, one)}};
    tbl[3] = '{1'b0, 3'b000, rand_bus(), rand_bus(),
               {el3(one, two, z), el3(one, z, z), el3(z, one, one)}};
    tbl[4] = '{1'b0, 3'b001,
               {el3(z, z, z), el3(z, z, z), el3(z, z, xm1)},
               {el3(z, z, z), el3(z, z, z), el3(z, z, x1)},
               {el3(one, two, z), el3(one, z, z), el3(z, z, red)}};

    bus.start = 1'b0;
    bus.sq    = 1'b0;
    bus.en    = '0;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    chk_bus("reset c", bus.c, '0);
    chk_bit("reset busy", bus.busy, 1'b0);
    chk_bit("reset done", bus.done, 1'b0);
    reset = 1'b0;
    c_model = '0;
    @(negedge clk);

    // Identity on channels 0 and 2, channel 1 masked off and left at zero.
    av = rand_bus();
    bv = rand_bus();
    av[0 +: W3] = el3(z, z, one);
    bv[2*W3 +: W3] = el3(z, z, one);
    ec = {av[2*W3 +: W3], el3(z, z, z), bv[0 +: W3]};
    launch(1'b0, 3'b101, av, bv, ec);
    @(negedge clk);
    chk_bit("busy after accepted start", bus.busy, 1'b1);
    wait_done();
    c_model = ec;

    for (int i = 0; i < 5; i++) begin
      launch(tbl[i].sq, tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].c);
      wait_done();
      c_model = tbl[i].c;
    end

    // Square mode against the golden model, b driven to garbage.
    av = rand_bus();
    ec = model(1'b1, 3'b111, av, {NB{1'b1}}, c_model);
    launch(1'b1, 3'b111, av, {NB{1'b1}}, ec);
    wait_done();
    c_model = ec;

    // Stray start mid-batch with different operands and mask must be ignored.
    av = rand_bus();
    bv = rand_bus();
    ec = model(1'b0, 3'b111, av, bv, c_model);
    launch(1'b0, 3'b111, av, bv, ec);
    repeat (40) @(negedge clk);
    bus.start = 1'b1;
    bus.sq    = 1'b1;
    bus.en    = 3'b001;
    bus.a     = rand_bus();
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    c_model = ec;

    // Reset during WAIT of channel 1, then a fresh batch started as reset drops.
    launch(1'b0, 3'b111, rand_bus(), rand_bus(), '0);
    repeat (CH_CYC + 4) @(negedge clk);
    chk_bit("busy before mid-batch reset", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_bit("mid reset busy", bus.busy, 1'b0);
    chk_bit("mid reset done", bus.done, 1'b0);
    chk_bus("mid reset c", bus.c, '0);
    exp_q.delete();
    c_model = '0;
    reset = 1'b0;
    av = rand_bus();
    bv = rand_bus();
    ec = model(1'b0, 3'b011, av, bv, c_model);
    launch(1'b0, 3'b011, av, bv, ec);
    wait_done();
    c_model = ec;

    // Back-to-back: second start in the cycle right after done.
    for (int i = 0; i < 2; i++) begin
      av = rand_bus();
      bv = rand_bus();
      ec = model(1'b0, 3'b110, av, bv, c_model);
      launch(1'b0, 3'b110, av, bv, ec);
      wait_done();
      c_model = ec;
    end

    for (int i = 0; i < 200; i++) begin
      e  = NCH'($urandom_range(0, 7));
      s  = ($urandom_range(0, 3) == 0);
      av = rand_bus();
      bv = rand_bus();
      ec = model(s, e, av, bv, c_model);
      launch(s, e, av, bv, ec);
      wait_done();
      c_model = ec;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
